// File: rtl/seg_pkg.sv
// Shared constants, state type and helpers for the 7-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

   // Both buses are active-low, so "all ones" means dark.
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Active-low segment codes, bit7 = dp (kept off), bits 6:0 = g..a.
   // Entry 15 is written first so that SEG_TABLE[n] is the code for hex digit n.
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   typedef enum logic {
      ST_GUARD = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   // Digits above the most significant nonzero nibble are marked for blanking.
   // Digit 0 always stays visible so a zero value still shows "0".
   function automatic logic [3:0] lzb_mask(input logic [15:0] v);
      return {v[15:12] == 4'h0, v[15:8] == 8'h00, v[15:4] == 12'h000, 1'b0};
   endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment decoder (g..a in bits 6:0).
// Latency: combinational.
// Backpressure: none.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[nib_i][6:0];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with guard interval and frame-aligned value commit.
// Latency: registered Moore outputs; a transferred value is visible at most one frame + GUARD + 1 cycles later.
// Backpressure: upd_ready low while a value waits for the frame boundary. SEG_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [15:0] upd_value,
   input  logic [3:0]  upd_dp,
   input  logic [3:0]  en_mask,
   output logic [7:0]  DISP,
   output logic [3:0]  AN,
   output logic        frame_tick
);

   localparam int CW = $clog2(SCAN_DIV);
   // cnt runs across the whole slot: 0..GUARD-1 dark, GUARD..SCAN_DIV-1 lit.
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] PRE_LAST   = CW'(SCAN_DIV - 2);

   state_t          state_q;
   logic [1:0]      idx_q;
   logic [CW-1:0]   cnt_q;
   logic [15:0]     shadow_q;
   logic [3:0]      shadow_dp_q;
   logic [15:0]     active_q;
   logic [3:0]      active_dp_q;
   logic            pending_q;
   logic [3:0]      an_q;
   logic [7:0]      disp_q;
   logic            tick_q;

   logic            show_entry;
   logic            slot_end;
   logic            frame_end;
   logic            pre_frame_end;
   logic            commit;
   logic            take;
   logic            digit_lit;
   logic [3:0]      nib;
   logic [3:0]      blank;
   logic [6:0]      seg;

   assign show_entry    = (state_q == ST_GUARD) && (cnt_q == GUARD_LAST);
   assign slot_end      = (state_q == ST_SHOW) && (cnt_q == SLOT_LAST);
   assign frame_end     = slot_end && (idx_q == 2'd3);
   // SHOW always lasts at least two cycles, so the cycle before the frame end is also in SHOW.
   assign pre_frame_end = (state_q == ST_SHOW) && (idx_q == 2'd3) && (cnt_q == PRE_LAST);

   assign commit = frame_end && pending_q;
   // A commit cycle still has pending_q set, so it can never also take a value.
   assign take   = upd_valid && !pending_q;

   assign nib       = active_q[{idx_q, 2'b00} +: 4];
   assign digit_lit = en_mask[idx_q] && !blank[idx_q];

   hex7seg u_hex7seg (
      .nib_i (nib),
      .seg_o (seg)
   );

`ifdef SEG_LZB_EN
   logic [3:0] blank_q;

   // Blank mask follows the active value, so it only changes when a value is committed.
   always_ff @(posedge clk) begin
      if (rst) begin
         blank_q <= lzb_mask(16'h0000);
      end else if (commit) begin
         blank_q <= lzb_mask(shadow_q);
      end
   end

   assign blank = blank_q;
`else
   assign blank = 4'b0000;
`endif

   // Slot FSM: dark guard then lit digit; output flops load on the edge that changes state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_GUARD;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         an_q    <= AN_OFF;
         disp_q  <= SEG_BLANK;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= pre_frame_end;
         if (show_entry) begin
            state_q <= ST_SHOW;
            cnt_q   <= cnt_q + CW'(1);
            // en_mask is only looked at here, so a slot never flickers mid-way.
            if (digit_lit) begin
               an_q   <= ~(4'b0001 << idx_q);
               disp_q <= {~active_dp_q[idx_q], seg};
            end else begin
               an_q   <= AN_OFF;
               disp_q <= SEG_BLANK;
            end
         end else if (slot_end) begin
            state_q <= ST_GUARD;
            idx_q   <= idx_q + 2'd1;
            cnt_q   <= '0;
            an_q    <= AN_OFF;
            disp_q  <= SEG_BLANK;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   // Update path: accept into the shadow, move to active only at the frame boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= 1'b0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         active_q    <= '0;
         active_dp_q <= '0;
      end else if (commit) begin
         active_q    <= shadow_q;
         active_dp_q <= shadow_dp_q;
         pending_q   <= 1'b0;
      end else if (take) begin
         shadow_q    <= upd_value;
         shadow_dp_q <= upd_dp;
         pending_q   <= 1'b1;
      end
   end

   assign upd_ready  = !pending_q;
   assign AN         = an_q;
   assign DISP       = disp_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, GUARD=2 (32-cycle frames).
module tb_seg_scan_ctrl;

   localparam int TB_DIV   = 8;
   localparam int TB_GUARD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        upd_valid;
   logic        upd_ready;
   logic [15:0] upd_value;
   logic [3:0]  upd_dp;
   logic [3:0]  en_mask;
   logic [7:0]  DISP;
   logic [3:0]  AN;
   logic        frame_tick;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .SCAN_DIV (TB_DIV),
      .GUARD    (TB_GUARD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_value  (upd_value),
      .upd_dp     (upd_dp),
      .en_mask    (en_mask),
      .DISP       (DISP),
      .AN         (AN),
      .frame_tick (frame_tick)
   );

   int checks = 0;
   int errors = 0;

   // Expected anodes/segments per slot, packed {slot3, slot2, slot1, slot0}.
   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic [15:0] exp_an;
      logic [31:0] exp_disp;
   } vec_t;

   vec_t vecs[4];

`ifdef SEG_LZB_EN
   localparam logic [15:0] ZERO_AN   = 16'hFFFE;
   localparam logic [31:0] ZERO_DISP = 32'hFFFFFFC0;
`else
   localparam logic [15:0] ZERO_AN   = 16'h7BDE;
   localparam logic [31:0] ZERO_DISP = 32'hC0C0C0C0;
`endif
   localparam logic [15:0] X_AN   = 16'h7BDE;
   localparam logic [31:0] X_DISP = 32'h999282F8;   // value 4567

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Samples frame cycles first_o..31 at negedges; the current sample must be the cycle before first_o.
   task automatic check_frame(input int first_o, input logic [15:0] ean,
                              input logic [31:0] edisp, input string tag);
      int s;
      int w;
      for (int o = first_o; o < 32; o++) begin
         @(negedge clk);
         s = o / TB_DIV;
         w = o % TB_DIV;
         if (w < TB_GUARD) begin
            chk($sformatf("%s AN o=%0d", tag, o), {28'h0, AN}, 32'hF);
            chk($sformatf("%s DISP o=%0d", tag, o), {24'h0, DISP}, 32'hFF);
         end else begin
            chk($sformatf("%s AN o=%0d", tag, o), {28'h0, AN}, {28'h0, ean[s*4 +: 4]});
            chk($sformatf("%s DISP o=%0d", tag, o), {24'h0, DISP}, {24'h0, edisp[s*8 +: 8]});
         end
         chk($sformatf("%s tick o=%0d", tag, o), {31'h0, frame_tick}, (o == 31) ? 32'h1 : 32'h0);
      end
   endtask

   task automatic wait_tick(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = frame_tick;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s frame_tick timeout got 0 want 1", tag);
      end
   endtask

   // One-cycle transfer; leaves the bench at the sample of the following cycle.
   task automatic send(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                       input string tag);
      en_mask = en;
      for (int i = 0; i < 200 && !upd_ready; i++) @(negedge clk);
      chk($sformatf("%s ready_before", tag), {31'h0, upd_ready}, 32'h1);
      upd_value = v;
      upd_dp    = dp;
      upd_valid = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
      chk($sformatf("%s ready_after", tag), {31'h0, upd_ready}, 32'h0);
   endtask

   initial begin
      bit seen;
      rst       = 1'b1;
      upd_valid = 1'b0;
      upd_value = 16'h0000;
      upd_dp    = 4'h0;
      en_mask   = 4'hF;

      vecs[0] = '{16'h12AF, 4'b0000, 4'b1111, 16'h7BDE, 32'hF9A4888E};
      vecs[1] = '{16'h12AF, 4'b0100, 4'b1111, 16'h7BDE, 32'hF924888E};
      vecs[2] = '{16'h12AF, 4'b0000, 4'b0101, 16'hFBFE, 32'hFFA4FF8E};
`ifdef SEG_LZB_EN
      vecs[3] = '{16'h0030, 4'b0000, 4'b1111, 16'hFFDE, 32'hFFFFB0C0};
`else
      vecs[3] = '{16'h0030, 4'b0000, 4'b1111, 16'h7BDE, 32'hC0C0B0C0};
`endif

      // Reset held for three cycles.
      repeat (3) @(negedge clk);
      chk("reset AN", {28'h0, AN}, 32'hF);
      chk("reset DISP", {24'h0, DISP}, 32'hFF);
      chk("reset ready", {31'h0, upd_ready}, 32'h1);
      chk("reset tick", {31'h0, frame_tick}, 32'h0);
      rst = 1'b0;
      check_frame(1, ZERO_AN, ZERO_DISP, "post_reset");

      // Table-driven display vectors: transfer, boundary commit, then one checked frame.
      for (int v = 0; v < 4; v++) begin
         send(vecs[v].value, vecs[v].dp, vecs[v].en, $sformatf("vec%0d", v));
         wait_tick($sformatf("vec%0d", v));
         check_frame(0, vecs[v].exp_an, vecs[v].exp_disp, $sformatf("vec%0d", v));
      end

      // Offer a second value while one is pending, including in the frame_tick cycle.
      send(16'h4567, 4'h0, 4'hF, "hold");
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         upd_valid = 1'b1;
         upd_value = 16'h89AB;
         upd_dp    = 4'hF;
         @(negedge clk);
         seen = frame_tick;
         chk($sformatf("hold ready_low i=%0d", i), {31'h0, upd_ready}, 32'h0);
      end
      chk("hold tick_seen", {31'h0, seen}, 32'h1);
      @(negedge clk);
      chk("ready_after_tick", {31'h0, upd_ready}, 32'h1);
      upd_valid = 1'b0;
      check_frame(1, X_AN, X_DISP, "hold_first");
      chk("tick_cycle_value_not_taken", {31'h0, upd_ready}, 32'h1);
      check_frame(0, X_AN, X_DISP, "hold_second");

      // Reset in the middle of digit 2 SHOW with a value still pending.
      send(16'h1111, 4'h0, 4'hF, "rst_pend");
      repeat (20) @(negedge clk);
      chk("pre_rst AN", {28'h0, AN}, 32'hB);
      chk("pre_rst DISP", {24'h0, DISP}, 32'h92);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst AN", {28'h0, AN}, 32'hF);
      chk("mid_rst DISP", {24'h0, DISP}, 32'hFF);
      chk("mid_rst ready", {31'h0, upd_ready}, 32'h1);
      chk("mid_rst tick", {31'h0, frame_tick}, 32'h0);
      rst = 1'b0;
      check_frame(1, ZERO_AN, ZERO_DISP, "rst_restart");
      check_frame(0, ZERO_AN, ZERO_DISP, "rst_discard");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
